// File: rtl/rx_psk_pkg.sv
// Shared types and helpers for the PSK receive deframer.
// Contents: FSM state enum, default sync word, bits-per-symbol encoding,
// popcount for the Hamming-distance sync match.
package rx_psk_pkg;

  typedef enum logic [1:0] {HUNT, HEADER, PAYLOAD} state_t;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;

  localparam logic [1:0] BPS_BPSK = 2'd1;
  localparam logic [1:0] BPS_QPSK = 2'd2;

  // Bits carried by one symbol; anything other than QPSK decodes as BPSK.
  function automatic logic [1:0] bps_bits(input logic [1:0] mode);
    return (mode == BPS_QPSK) ? 2'd2 : BPS_BPSK;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/rx_psk_deframer_if.sv
// AXI-Stream byte output of the deframer.
//   tdata  payload byte       tvalid byte valid     tready downstream ready
//   tlast  last byte of frame tuser  frame was received 180 deg inverted
interface rx_psk_deframer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through FIFO with count-based full/empty.
//   clk, rst_n   clock, async active-low reset (flushes contents)
//   push, din    write request and data (ignored when full unless popping)
//   pop          read request (ignored when empty)
//   dout, valid  head entry (zero when empty) and non-empty flag
//   full         no free slot
module rx_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] ONE      = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && valid;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rx_psk_deframer.sv
// PSK hard-symbol deframer: serialises BPSK/QPSK symbols to one bit per
// clock, hunts a sync word with Hamming tolerance and 180 deg inversion
// detection, reads a length header and pushes payload bytes into a FIFO.
//   clk_32M768, rst_n_32M768  clock, async active-low reset
//   sym_ce, sym_data          symbol strobe and bits (MSB first on air)
//   bps_mode                  1=BPSK, 2=QPSK, sampled on sym_ce
//   sync_err_max              max bit errors accepted on sync
//   m                         AXI-Stream byte output {tuser=inverted, tlast}
//   frame_active              high in HEADER/PAYLOAD
//   overflow                  pulse when a byte is dropped on a full FIFO
//   frame_count               completed frames, wraps
// Requires MAX_BPS >= 2.
module rx_psk_deframer
  import rx_psk_pkg::*;
#(
  parameter int                  MAX_BPS    = 2,
  parameter int                  SYNC_LEN   = 16,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD  = SYNC_LEN'(SYNC_WORD_DEF),
  parameter int                  LEN_WIDTH  = 8,
  parameter int                  FIFO_DEPTH = 16,
  parameter int                  ERR_WIDTH  = 4
) (
  input  logic                 clk_32M768,
  input  logic                 rst_n_32M768,
  input  logic                 sym_ce,
  input  logic [MAX_BPS-1:0]   sym_data,
  input  logic [1:0]           bps_mode,
  input  logic [ERR_WIDTH-1:0] sync_err_max,
  rx_psk_deframer_if.master    m,
  output logic                 frame_active,
  output logic                 overflow,
  output logic [15:0]          frame_count
);
  localparam int BLW = $clog2(MAX_BPS + 1);
  localparam int CW  = $clog2((LEN_WIDTH > 8) ? LEN_WIDTH : 8);

  state_t               state, state_nx;
  logic                 inv, inv_nx;
  logic [MAX_BPS-1:0]   sreg;
  logic [BLW-1:0]       bits_left, n_sym;
  logic                 bit_vld, bit_in, db;
  logic [SYNC_LEN-1:0]  hist, hist_nx, x0, x1;
  logic [5:0]           d0, d1;
  logic [LEN_WIDTH-1:0] len_sh, len_nx, rem;
  logic [7:0]           byte_sh, byte_nx;
  logic [CW-1:0]        bcnt;
  logic                 hdr_end, push, frame_done, last_byte;
  logic                 fifo_full, pop;
  logic [9:0]           fifo_dout;

  // Serialiser: symbol is left-aligned so the on-air MSB sits at sreg's top.
  assign n_sym   = BLW'(bps_bits(bps_mode));
  assign bit_vld = (bits_left != '0) && !sym_ce;
  assign bit_in  = sreg[MAX_BPS-1];
  assign db      = bit_in ^ inv;

  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      sreg      <= '0;
      bits_left <= '0;
    end else if (sym_ce) begin
      sreg      <= sym_data << (BLW'(MAX_BPS) - n_sym);
      bits_left <= n_sym;
    end else if (bits_left != '0) begin
      sreg      <= sreg << 1;
      bits_left <= bits_left - BLW'(1);
    end
  end

  // Sync match looks at the history including the bit being consumed now.
  assign hist_nx   = {hist[SYNC_LEN-2:0], bit_in};
  assign x0        = hist_nx ^ SYNC_WORD;
  assign x1        = ~x0;
  assign d0        = popcount(32'(x0));
  assign d1        = popcount(32'(x1));
  assign len_nx    = {len_sh[LEN_WIDTH-2:0], db};
  assign byte_nx   = {byte_sh[6:0], db};
  assign last_byte = (rem == LEN_WIDTH'(1));

  always_comb begin
    state_nx   = state;
    inv_nx     = inv;
    hdr_end    = 1'b0;
    push       = 1'b0;
    frame_done = 1'b0;
    if (bit_vld) begin
      case (state)
        HUNT: begin
          if (32'(d0) <= 32'(sync_err_max)) begin
            state_nx = HEADER;
            inv_nx   = 1'b0;
          end else if (32'(d1) <= 32'(sync_err_max)) begin
            state_nx = HEADER;
            inv_nx   = 1'b1;
          end
        end
        HEADER: begin
          if (bcnt == CW'(LEN_WIDTH - 1)) begin
            hdr_end  = 1'b1;
            state_nx = (len_nx == '0) ? HUNT : PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (bcnt == CW'(7)) begin
            push = 1'b1;
            if (last_byte) begin
              frame_done = 1'b1;
              state_nx   = HUNT;
            end
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      state       <= HUNT;
      inv         <= 1'b0;
      hist        <= '0;
      len_sh      <= '0;
      rem         <= '0;
      byte_sh     <= '0;
      bcnt        <= '0;
      frame_count <= '0;
    end else begin
      state <= state_nx;
      inv   <= inv_nx;
      if (bit_vld) begin
        hist <= frame_done ? '0 : hist_nx;
        if (state == HEADER)  len_sh  <= len_nx;
        if (state == PAYLOAD) byte_sh <= byte_nx;
        if (state == HUNT || hdr_end || push) bcnt <= '0;
        else                                  bcnt <= bcnt + CW'(1);
        if (hdr_end)   rem <= len_nx;
        else if (push) rem <= rem - LEN_WIDTH'(1);
      end
      // A dropped last byte still completes the frame.
      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end

  assign pop          = m.tvalid && m.tready;
  assign overflow     = push && fifo_full && !pop;
  assign frame_active = (state != HUNT);

  rx_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(10)) u_fifo (
    .clk   (clk_32M768),
    .rst_n (rst_n_32M768),
    .push  (push),
    .din   ({inv, last_byte, byte_nx}),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (m.tvalid),
    .full  (fifo_full)
  );

  assign m.tuser = fifo_dout[9];
  assign m.tlast = fifo_dout[8];
  assign m.tdata = fifo_dout[7:0];

endmodule

// File: tb/tb_rx_psk_deframer.sv
module tb_rx_psk_deframer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sym_ce = 1'b0;
  logic [1:0]  sym_data = 2'b00;
  logic [1:0]  bps_mode = 2'd1;
  logic [3:0]  sync_err_max = 4'd0;
  logic        frame_active, overflow;
  logic [15:0] frame_count;

  rx_psk_deframer_if bus();

  rx_psk_deframer dut (
    .clk_32M768   (clk),
    .rst_n_32M768 (rst_n),
    .sym_ce       (sym_ce),
    .sym_data     (sym_data),
    .bps_mode     (bps_mode),
    .sync_err_max (sync_err_max),
    .m            (bus),
    .frame_active (frame_active),
    .overflow     (overflow),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int         nvec = 0, nerr = 0;
  int         cyc = 0, ovf_cnt = 0;
  logic [9:0] rxq[$];
  int         rxcyc[$];
  int         symcyc[$];
  logic       sq[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && bus.tvalid && bus.tready) begin
      rxq.push_back({bus.tuser, bus.tlast, bus.tdata});
      rxcyc.push_back(cyc);
    end
    if (rst_n && overflow) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [9:0] exp);
    check(tag, (idx < rxq.size()) ? 32'(rxq[idx]) : 32'hDEAD, 32'(exp));
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sq.push_back(b[i]);
  endtask

  task automatic add_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) sq.push_back(w[i]);
  endtask

  // Sync + len 3 + A5 3C 0F, every bit XORed with x.
  task automatic add_frame(input logic [7:0] x, input logic [15:0] sync);
    add_word(sync);
    add_byte(8'h03 ^ x);
    add_byte(8'hA5 ^ x);
    add_byte(8'h3C ^ x);
    add_byte(8'h0F ^ x);
  endtask

  task automatic send_sym(input logic [1:0] d, input int gap);
    @(posedge clk); #1;
    sym_ce = 1'b1;
    sym_data = d;
    symcyc.push_back(cyc);
    @(posedge clk); #1;
    sym_ce = 1'b0;
    repeat (gap - 1) @(posedge clk);
  endtask

  // BPSK drives both symbol bits with the same value.
  task automatic send_stream(input logic [1:0] mode, input int gap);
    logic b0, b1;
    bps_mode = mode;
    if (mode == 2'd2) begin
      while (sq.size() >= 2) begin
        b0 = sq.pop_front();
        b1 = sq.pop_front();
        send_sym({b0, b1}, gap);
      end
    end else begin
      while (sq.size() > 0) begin
        b0 = sq.pop_front();
        send_sym({b0, b0}, gap);
      end
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int base, ovf0;

  initial begin
    bus.tready = 1'b1;
    #3;
    check("rst_tvalid", 32'(bus.tvalid), 0);
    check("rst_tdata", 32'(bus.tdata), 0);
    check("rst_frame_active", 32'(frame_active), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // BPSK, exact sync
    base = rxq.size();
    add_frame(8'h00, 16'hEB90);
    send_stream(2'd1, 3);
    check("bpsk_nbeats", rxq.size() - base, 3);
    check_beat("bpsk_b0", base + 0, 10'h0A5);
    check_beat("bpsk_b1", base + 1, 10'h03C);
    check_beat("bpsk_b2", base + 2, 10'h10F);
    check("bpsk_frame_count", 32'(frame_count), 1);
    check("bpsk_frame_active", 32'(frame_active), 0);

    // QPSK, slow symbol rate, byte latency
    base = rxq.size();
    symcyc.delete();
    add_frame(8'h00, 16'hEB90);
    send_stream(2'd2, 31);
    check("qpsk_nbeats", rxq.size() - base, 3);
    check_beat("qpsk_b0", base + 0, 10'h0A5);
    check_beat("qpsk_b1", base + 1, 10'h03C);
    check_beat("qpsk_b2", base + 2, 10'h10F);
    for (int j = 0; j < 3; j++)
      check("qpsk_latency", (base + j < rxcyc.size()) ? rxcyc[base + j] - symcyc[15 + 4 * j] : -1, 3);
    check("qpsk_frame_count", 32'(frame_count), 2);

    // Inverted stream, exact
    base = rxq.size();
    add_frame(8'hFF, 16'h146F);
    send_stream(2'd1, 3);
    check("inv_nbeats", rxq.size() - base, 3);
    check_beat("inv_b0", base + 0, 10'h2A5);
    check_beat("inv_b1", base + 1, 10'h23C);
    check_beat("inv_b2", base + 2, 10'h30F);
    check("inv_frame_count", 32'(frame_count), 3);

    // Inverted, 2 sync bit errors within tolerance 2
    sync_err_max = 4'd2;
    base = rxq.size();
    add_frame(8'hFF, 16'h146F ^ 16'hC000);
    send_stream(2'd1, 3);
    check("err2_nbeats", rxq.size() - base, 3);
    check_beat("err2_b0", base + 0, 10'h2A5);
    check_beat("err2_b2", base + 2, 10'h30F);
    check("err2_frame_count", 32'(frame_count), 4);

    // 3 sync bit errors: no lock
    base = rxq.size();
    add_word(16'h146F ^ 16'hE000);
    send_stream(2'd1, 3);
    check("err3_frame_active", 32'(frame_active), 0);
    check("err3_nbeats", rxq.size() - base, 0);
    sync_err_max = 4'd0;
    do_reset();
    check("rst2_frame_count", 32'(frame_count), 0);

    // Zero-length header, then a valid frame
    base = rxq.size();
    add_word(16'hEB90);
    add_byte(8'h00);
    send_stream(2'd1, 3);
    check("len0_frame_active", 32'(frame_active), 0);
    check("len0_nbeats", rxq.size() - base, 0);
    add_frame(8'h00, 16'hEB90);
    send_stream(2'd1, 3);
    check("len0_next_nbeats", rxq.size() - base, 3);
    check_beat("len0_next_b0", base + 0, 10'h0A5);
    check_beat("len0_next_b2", base + 2, 10'h10F);
    check("len0_frame_count", 32'(frame_count), 1);

    // Overflow: 20 bytes into 16 slots with tready low
    bus.tready = 1'b0;
    ovf0 = ovf_cnt;
    add_word(16'hEB90);
    add_byte(8'd20);
    for (int i = 0; i < 20; i++) add_byte(8'h40 + 8'(i));
    send_stream(2'd1, 3);
    check("ovf_pulses", ovf_cnt - ovf0, 4);
    check("ovf_frame_count", 32'(frame_count), 2);
    check("ovf_tvalid", 32'(bus.tvalid), 1);
    check("ovf_frame_active", 32'(frame_active), 0);
    base = rxq.size();
    bus.tready = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("ovf_nbeats", rxq.size() - base, 16);
    for (int i = 0; i < 16; i++) check_beat("ovf_beat", base + i, {2'b00, 8'h40 + 8'(i)});
    check("ovf_drained", 32'(bus.tvalid), 0);

    // Async reset mid-payload
    bus.tready = 1'b0;
    add_word(16'hEB90);
    add_byte(8'h03);
    add_byte(8'hA5);
    for (int i = 7; i >= 4; i--) sq.push_back(1'(8'h3C >> i));
    send_stream(2'd1, 3);
    check("mid_frame_active", 32'(frame_active), 1);
    check("mid_tvalid", 32'(bus.tvalid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(bus.tvalid), 0);
    check("mid_rst_frame_active", 32'(frame_active), 0);
    check("mid_rst_frame_count", 32'(frame_count), 0);
    #15 rst_n = 1'b1;
    bus.tready = 1'b1;
    @(posedge clk); #1;
    base = rxq.size();
    add_frame(8'h00, 16'hEB90);
    send_stream(2'd1, 3);
    check("post_rst_nbeats", rxq.size() - base, 3);
    check_beat("post_rst_b0", base + 0, 10'h0A5);
    check_beat("post_rst_b1", base + 1, 10'h03C);
    check_beat("post_rst_b2", base + 2, 10'h10F);
    check("post_rst_frame_count", 32'(frame_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
